// File: rtl/wf_bram_stream_reader_pkg.sv
// Shared widths and FSM encoding for the BRAM stream reader and its skid buffer.
package wf_bram_pkg;
  localparam int BRAM_AW    = 8;
  localparam int BRAM_DW    = 16;
  localparam int BRAM_DEPTH = 1 << BRAM_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/wf_bram_stream_reader_skid2.sv
// Two-entry FIFO that catches BRAM read data (plus its last tag) so backpressure
// never loses a word already in flight.
module wf_skid2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);
endmodule

// File: rtl/wf_bram_stream_reader.sv
// Streams a contiguous BRAM word range out on valid/ready, hiding the 1-cycle read latency.
// Optional WF_BRAM_STREAM_LOOP_EN adds a `loop` input that restarts the same range.
//
// state    | meaning
// ST_IDLE  | waiting for start; no reads issued
// ST_READ  | issuing reads while the skid buffer has room
// ST_DRAIN | all reads issued; waiting for the final handshake
module wf_bram_stream_reader import wf_bram_pkg::*; #(
  parameter int AW = BRAM_AW,
  parameter int DW = BRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
`ifdef WF_BRAM_STREAM_LOOP_EN
  input  logic          loop,
`endif
  output logic [AW-1:0] bram_raddr,
  output logic          bram_ren,
  input  logic [DW-1:0] bram_rdata,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          busy,
  output logic          done
);
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, base_cap_q, base_cap_d;
  logic [AW:0]   rem_q, rem_d, len_cap_q, len_cap_d;
  logic          infl_q, infl_d, infl_last_q, infl_last_d, done_q, done_d;
  logic [DW:0]   head;
  logic [1:0]    count, occupancy;
  logic          empty, pop, issue, final_hs, loop_req;

`ifdef WF_BRAM_STREAM_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  // A word leaving this cycle frees its slot, which keeps 1 word/clk under m_ready=1.
  assign pop       = !empty && m_ready;
  assign final_hs  = pop && head[DW];
  assign occupancy = count - {1'b0, pop} + {1'b0, infl_q};
  assign issue     = (state_q == ST_READ) && (occupancy < 2'd2);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    base_cap_d  = base_cap_q;
    len_cap_d   = len_cap_q;
    infl_d      = issue;
    infl_last_d = issue && (rem_q == (AW+1)'(1));
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_READ;
            addr_d     = base_addr;
            rem_d      = length;
            base_cap_d = base_addr;
            len_cap_d  = length;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (AW+1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (final_hs) begin
          if (loop_req) begin
            state_d = ST_READ;
            addr_d  = base_cap_q;
            rem_d   = len_cap_q;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      base_cap_q  <= '0;
      len_cap_q   <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      base_cap_q  <= base_cap_d;
      len_cap_q   <= len_cap_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  wf_skid2 #(.W(DW+1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (infl_q),
    .push_data ({infl_last_q, bram_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  assign bram_raddr = addr_q;
  assign bram_ren   = issue;
  assign m_valid    = !empty;
  assign m_data     = head[DW-1:0];
  assign m_last     = head[DW];
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
endmodule
